// File: rtl/pcm_halfband_decim.sv
`default_nettype none
// ============================================================================
// Module   : pcm_halfband_decim
// Purpose  : Post-CIC decimate-by-2 compensation FIR. Keeps a 16-entry
//            circular history of CIC words and, on every second sample, runs
//            an 8-tap sequential MAC (one tap per clk), then rounds, scales
//            by 1/128, saturates and presents the result on a valid/ready
//            output register.
// Options  : PCM_HALFBAND_SATCNT_EN adds the 16-bit saturating sat_count port
//            that counts results changed by the output clamp.
// Revision : 1.0 - initial release
// ============================================================================
module pcm_halfband_decim #(
    parameter int W_IN  = 24,
    parameter int W_OUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [W_IN-1:0]  din,
    input  logic                    din_valid,
    output logic signed [W_OUT-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    busy,
    output logic                    overrun
`ifdef PCM_HALFBAND_SATCNT_EN
    ,
    output logic [15:0]             sat_count
`endif
);

    localparam int ACC_W = W_IN + 9;

    // Clamp limits expressed at accumulator width so the compare is exact.
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [W_IN-1:0]  hist_q [16];
    logic [3:0]              ptr_q;
    logic                    phase_q;
    logic [3:0]              base_q, base_d;
    logic [2:0]              k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [W_OUT-1:0] dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;
    logic                    overrun_q, overrun_d;

    logic signed [7:0]       w_coef;
    logic signed [W_IN-1:0]  w_tap;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_rnd;
    logic signed [ACC_W-1:0] w_y;
    logic                    w_hi;
    logic                    w_lo;
    logic signed [W_OUT-1:0] w_clamped;

    // Symmetric compensation taps; they sum to 128 for unity DC gain.
    function automatic logic signed [7:0] coef_rom(input logic [2:0] k);
        case (k)
            3'd0, 3'd7: coef_rom = -8'sd2;
            3'd2, 3'd5: coef_rom = 8'sd18;
            3'd3, 3'd4: coef_rom = 8'sd48;
            default:    coef_rom = 8'sd0;
        endcase
    endfunction

    // Tap product and round/scale/clamp datapath.
    always_comb begin
        w_coef = coef_rom(k_q);
        w_tap  = hist_q[base_q - {1'b0, k_q}];
        w_prod = $signed({{(ACC_W-W_IN){w_tap[W_IN-1]}}, w_tap})
               * $signed({{(ACC_W-8){w_coef[7]}}, w_coef});
        w_rnd  = acc_q + $signed(ACC_W'(64));
        w_y    = w_rnd >>> 7;
        w_hi   = (w_y > Y_MAX);
        w_lo   = (w_y < Y_MIN);
        if (w_hi) begin
            w_clamped = {1'b0, {(W_OUT-1){1'b1}}};
        end else if (w_lo) begin
            w_clamped = {1'b1, {(W_OUT-1){1'b0}}};
        end else begin
            w_clamped = w_y[W_OUT-1:0];
        end
    end

    // Sample capture: every strobe writes the history, even mid-computation.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                hist_q[i] <= '0;
            end
            ptr_q   <= 4'd0;
            phase_q <= 1'b0;
        end else if (din_valid) begin
            hist_q[ptr_q] <= din;
            ptr_q         <= ptr_q + 4'd1;
            phase_q       <= ~phase_q;
        end
    end

    // State, MAC and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            base_q       <= 4'd0;
            k_q          <= 3'd0;
            acc_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state: trigger on the second sample of each pair, MAC, then round.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        k_d          = k_q;
        acc_d        = acc_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (din_valid && phase_q) begin
                    state_d = ST_MAC;
                    base_d  = ptr_q;
                    k_d     = 3'd0;
                end
            end
            ST_MAC: begin
                acc_d = ((k_q == 3'd0) ? '0 : acc_q) + w_prod;
                k_d   = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                // Load when the output slot is empty or drains this cycle.
                if (!dout_valid_q || dout_ready) begin
                    dout_d       = w_clamped;
                    dout_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

`ifdef PCM_HALFBAND_SATCNT_EN
    logic [15:0] sat_q;

    // Count clamped results, including ones later dropped; sticks at max.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_q <= 16'd0;
        end else if ((state_q == ST_ROUND) && (w_hi || w_lo) && (sat_q != 16'hFFFF)) begin
            sat_q <= sat_q + 16'd1;
        end
    end

    assign sat_count = sat_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcm_halfband_decim.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcm_halfband_decim
// Purpose  : Self-checking bench for pcm_halfband_decim. A sample-list model
//            computes each decimated output from the filter definition with
//            plain integer arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcm_halfband_decim;

    localparam int W_IN  = 24;
    localparam int W_OUT = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [W_IN-1:0]  din = '0;
    logic             din_valid = 1'b0;
    logic [W_OUT-1:0] dout;
    logic             dout_valid;
    logic             dout_ready = 1'b1;
    logic             busy;
    logic             overrun;
`ifdef PCM_HALFBAND_SATCNT_EN
    logic [15:0]      sat_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: every sample since reset, plus clamp count.
    int samples[$];
    int sat_exp = 0;
    int coefs[8] = '{-2, 0, 18, 48, 48, 18, 0, -2};

    pcm_halfband_decim #(.W_IN(W_IN), .W_OUT(W_OUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun)
`ifdef PCM_HALFBAND_SATCNT_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    always #5 clk = ~clk;

    // Filter output for sample n: weighted sum, round half up, floor-divide
    // by 128, then clamp to the output range.
    function automatic int model_out(input int n, output bit sat);
        longint acc = 0;
        longint num, q;
        longint lim_hi = (longint'(1) <<< (W_OUT-1)) - 1;
        longint lim_lo = -(longint'(1) <<< (W_OUT-1));
        for (int k = 0; k < 8; k++) begin
            if (n - k >= 0) acc += longint'(coefs[k]) * longint'(samples[n-k]);
        end
        num = acc + 64;
        q   = num / 128;
        if ((num % 128 != 0) && (num < 0)) q = q - 1;
        sat = 1'b0;
        if (q > lim_hi) begin q = lim_hi; sat = 1'b1; end
        if (q < lim_lo) begin q = lim_lo; sat = 1'b1; end
        return int'(q);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; din_valid = 1'b0; dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        samples.delete();
        sat_exp = 0;
    endtask

    // One strobe followed by 15 idle cycles. Reports rise latency of
    // dout_valid, busy cycle count and the dout/dout_valid seen 10 clk on.
    task automatic drive_sample(input int v, input bit rdy_def, input int pulse_j,
                                output bit trig, output int exp_y, output int lat,
                                output int busy_n, output int y10, output bit dv10);
        bit dv_prev;
        bit sat;
        @(negedge clk);
        din = W_IN'(v); din_valid = 1'b1; dout_ready = rdy_def;
        samples.push_back(v);
        trig  = (samples.size() % 2 == 0);
        exp_y = 0;
        if (trig) begin
            exp_y = model_out(samples.size() - 1, sat);
            if (sat && sat_exp < 65535) sat_exp++;
        end
        dv_prev = dout_valid;
        @(negedge clk);
        din_valid = 1'b0;
        lat = 0; busy_n = 0; y10 = 0; dv10 = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            if (j > 1) @(negedge clk);
            busy_n += int'(busy);
            if (dout_valid && !dv_prev && lat == 0) lat = j;
            dv_prev = dout_valid;
            if (j == 10) begin
                y10  = int'($signed(dout));
                dv10 = dout_valid;
            end
            dout_ready = rdy_def || (j == pulse_j);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout got=%0d want=0", dout); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid got=%b want=0", dout_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b want=0", overrun); end
`ifdef PCM_HALFBAND_SATCNT_EN
        n_checks++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL reset_sat_count got=%0d want=0", sat_count); end
`endif
    endtask

    task automatic test_impulse(input string tag);
        int imp_exp[4] = '{0, 375, 141, -16};
        int oi = 0;
        bit trig, dv10;
        int exp_y, lat, busy_n, y10;
        for (int i = 0; i < 8; i++) begin
            drive_sample((i == 0) ? 1000 : 0, 1'b1, 0, trig, exp_y, lat, busy_n, y10, dv10);
            if (trig) begin
                n_checks++; if (y10 !== imp_exp[oi]) begin n_fail++; $display("FAIL %s_out%0d got=%0d want=%0d", tag, oi, y10, imp_exp[oi]); end
                n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL %s_latency%0d got=%0d want=10", tag, oi, lat); end
                n_checks++; if (busy_n !== 9) begin n_fail++; $display("FAIL %s_busy%0d got=%0d want=9", tag, oi, busy_n); end
                oi++;
            end else begin
                n_checks++; if (busy_n !== 0) begin n_fail++; $display("FAIL %s_idle_busy got=%0d want=0", tag, busy_n); end
            end
        end
    endtask

    task automatic test_dc();
        int oi = 0;
        bit trig, dv10;
        int exp_y, lat, busy_n, y10;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive_sample(5000, 1'b1, 0, trig, exp_y, lat, busy_n, y10, dv10);
            if (trig) begin
                n_checks++; if (y10 !== exp_y) begin n_fail++; $display("FAIL dc_model%0d got=%0d want=%0d", oi, y10, exp_y); end
                if (oi >= 3) begin
                    n_checks++; if (y10 !== 5000) begin n_fail++; $display("FAIL dc_value%0d got=%0d want=5000", oi, y10); end
                end
                oi++;
            end
        end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL dc_overrun got=%b want=0", overrun); end
    endtask

    task automatic test_saturation();
        int oi = 0;
        bit trig, dv10;
        int exp_y, lat, busy_n, y10;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive_sample((i < 10) ? 40000 : -40000, 1'b1, 0, trig, exp_y, lat, busy_n, y10, dv10);
            if (trig) begin
                n_checks++; if (y10 !== exp_y) begin n_fail++; $display("FAIL sat_model%0d got=%0d want=%0d", oi, y10, exp_y); end
                if (oi == 4) begin
                    n_checks++; if (y10 !== 32767) begin n_fail++; $display("FAIL sat_pos got=%0d want=32767", y10); end
                end
                if (oi == 9) begin
                    n_checks++; if (y10 !== -32768) begin n_fail++; $display("FAIL sat_neg got=%0d want=-32768", y10); end
                end
                oi++;
            end
        end
`ifdef PCM_HALFBAND_SATCNT_EN
        n_checks++; if (sat_count !== 16'(sat_exp)) begin n_fail++; $display("FAIL sat_count got=%0d want=%0d", sat_count, sat_exp); end
`endif
    endtask

    task automatic test_random();
        bit trig, dv10;
        int exp_y, lat, busy_n, y10, v;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (i % 4 < 2) v = int'($urandom_range(0, (1 << 24) - 1)) - (1 << 23);
            else           v = int'($urandom_range(0, (1 << 17) - 1)) - (1 << 16);
            drive_sample(v, 1'b1, 0, trig, exp_y, lat, busy_n, y10, dv10);
            if (trig) begin
                n_checks++; if (y10 !== exp_y) begin n_fail++; $display("FAIL random_out%0d got=%0d want=%0d", i, y10, exp_y); end
                n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL random_latency%0d got=%0d want=10", i, lat); end
            end
        end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL random_overrun got=%b want=0", overrun); end
`ifdef PCM_HALFBAND_SATCNT_EN
        n_checks++; if (sat_count !== 16'(sat_exp)) begin n_fail++; $display("FAIL random_sat_count got=%0d want=%0d", sat_count, sat_exp); end
`endif
    endtask

    task automatic test_backpressure();
        bit trig, dv10;
        int exp_y, exp1, lat, busy_n, y10, v;
        do_reset();
        exp1 = 0;
        for (int i = 0; i < 4; i++) begin
            v = int'($urandom_range(0, 200000)) - 100000;
            drive_sample(v, 1'b0, 0, trig, exp_y, lat, busy_n, y10, dv10);
            if (i == 1) begin
                exp1 = exp_y;
                n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid got=%b want=1", dout_valid); end
                n_checks++; if (int'($signed(dout)) !== exp1) begin n_fail++; $display("FAIL bp_first_value got=%0d want=%0d", $signed(dout), exp1); end
            end
        end
        n_checks++; if (int'($signed(dout)) !== exp1) begin n_fail++; $display("FAIL bp_held_value got=%0d want=%0d", $signed(dout), exp1); end
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL bp_held_valid got=%b want=1", dout_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun got=%b want=1", overrun); end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_valid got=%b want=0", dout_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun_sticky got=%b want=1", overrun); end
`ifdef PCM_HALFBAND_SATCNT_EN
        n_checks++; if (sat_count !== 16'(sat_exp)) begin n_fail++; $display("FAIL bp_sat_count got=%0d want=%0d", sat_count, sat_exp); end
`endif
    endtask

    task automatic test_simultaneous();
        bit trig, dv10;
        int exp_y, lat, busy_n, y10, v;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            v = int'($urandom_range(0, 400000)) - 200000;
            drive_sample(v, 1'b0, (i == 3) ? 9 : 0, trig, exp_y, lat, busy_n, y10, dv10);
        end
        n_checks++; if (dv10 !== 1'b1) begin n_fail++; $display("FAIL sim_valid got=%b want=1", dv10); end
        n_checks++; if (y10 !== exp_y) begin n_fail++; $display("FAIL sim_value got=%0d want=%0d", y10, exp_y); end
        n_checks++; if (int'($signed(dout)) !== exp_y) begin n_fail++; $display("FAIL sim_value_held got=%0d want=%0d", $signed(dout), exp_y); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL sim_overrun got=%b want=0", overrun); end
        dout_ready = 1'b1;
    endtask

    task automatic test_reset_mid_mac();
        bit trig, dv10;
        int exp_y, lat, busy_n, y10;
        do_reset();
        drive_sample(1000, 1'b1, 0, trig, exp_y, lat, busy_n, y10, dv10);
        @(negedge clk);
        din = '0; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midmac_busy_before got=%b want=1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        samples.delete();
        sat_exp = 0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midmac_busy got=%b want=0", busy); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL midmac_valid got=%b want=0", dout_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL midmac_overrun got=%b want=0", overrun); end
        test_impulse("replay");
    endtask

    initial begin
        test_reset();
        test_impulse("impulse");
        test_dc();
        test_saturation();
        test_random();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_mac();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcm_halfband_decim.md
Name: pcm_halfband_decim

Overview:
- Post-CIC decimate-by-2 compensation FIR stage. Sits directly downstream of the 2-stage PDM CIC decimator.
- Takes one signed CIC output word per din_valid strobe, keeps a 16-entry circular sample history and, on every 2nd sample, runs an 8-tap multiply-accumulate (MAC) sequentially (one tap per clk).
- Rounds, scales and saturates each result, then presents it on a valid/ready output register.

Parameters:
- W_IN, 24, input sample width (signed; matches CIC output width)
- W_OUT, 16, output PCM width (signed)

Ports:
- clk  in  1  system clock (same clk as the CIC integrators)
- reset  in  1  synchronous, active-high
- din  in  W_IN  signed CIC output sample
- din_valid  in  1  one-clk strobe; din is captured on this cycle
- dout  out  W_OUT  signed filtered, decimated sample
- dout_valid  out  1  dout holds an unconsumed result
- dout_ready  in  1  consumer accepts dout when dout_valid && dout_ready
- busy  out  1  high while MAC/ROUND states active
- overrun  out  1  sticky; set when a result is dropped because the output is still occupied

Behaviour:
- Reset (synchronous, active-high): state=IDLE; write ptr=0; phase=0; all 16 history entries=0; accumulator=0; dout=0; dout_valid=0; busy=0; overrun=0. Reset mid-MAC aborts the computation; no result is emitted.
- Coefficient ROM, taps k=0..7: -2, 0, 18, 48, 48, 18, 0, -2 (sum 128, unity DC gain after >>7).
- Input capture:
  - On every din_valid, including during MAC/ROUND: write din at ptr, ptr<=ptr+1 (mod 16), phase toggles.
  - Input spacing must be >=10 clk. Upstream guarantees this, since the comb stage runs at clk/32. Closer spacing is not checked.
- Trigger: a din_valid arriving when phase==1 (2nd, 4th, ... sample after reset) captures base=index of that sample and enters MAC on the next clk. The history holds 16 entries, so writes arriving during MAC never overwrite taps being read.
- States:
  - IDLE: wait for trigger.
  - MAC: 8 cycles, k=0..7; acc += coef[k]*hist[base-k mod 16]; acc cleared at k=0. Accumulator width W_IN+9 signed, no overflow possible.
  - ROUND: y = (acc + 64) >>> 7 (arithmetic shift, floor); clamp to [-2^(W_OUT-1), 2^(W_OUT-1)-1]. Then:
    - dout_valid==0, or dout_valid && dout_ready this cycle: load dout, set dout_valid.
    - Otherwise: drop the result, set overrun; dout is unchanged.
  - After ROUND: return to IDLE.
- Latency: trigger din_valid at cycle t -> MAC t+1..t+8 -> ROUND t+9 -> dout_valid=1 from t+10.
- Output handshake:
  - dout_valid && dout_ready clears dout_valid next clk, unless ROUND loads a new result in the same cycle; then dout_valid stays 1 with the new value.
  - dout is stable while dout_valid && !dout_ready.
- busy = state!=IDLE.
- overrun is cleared only by reset.

Optional Feature:
- Macro: PCM_HALFBAND_SATCNT_EN.
- Defined: adds output port sat_count (16 bits, unsigned).
  - Increments in ROUND whenever the clamp changes the value, including results later dropped by overrun.
  - Saturates at 65535. Reset -> 0.
- Undefined: no sat_count port, no counter logic; all other behaviour identical.

Test Plan:
- Impulse (W_OUT=16, dout_ready=1, din_valid every 16 clk): samples 1000, then zeros -> outputs 0, 375, 141, -16, 0, 0...; each dout_valid rises exactly 10 clk after its trigger strobe; busy high 9 clk per trigger.
- DC: constant din=5000 -> from the 4th output onward, dout=5000 on every output; overrun=0.
- Saturation: constant +40000 -> dout=32767; then constant -40000 -> dout=-32768. With PCM_HALFBAND_SATCNT_EN, sat_count increments by 1 per clamped output.
- Backpressure: dout_ready=0 across two triggers -> first result held unchanged; second dropped; overrun=1. Then dout_ready=1 for 1 clk -> dout_valid=0 next clk; overrun stays 1.
- Simultaneous: dout_ready=1 in the same cycle as ROUND -> new value loaded, dout_valid stays 1, overrun=0.
- Reset mid-MAC: reset asserted at MAC k=4 -> next clk busy=0, dout_valid=0, overrun=0. Replaying the impulse test afterwards reproduces 0, 375, 141, -16.
